jtpopeye_dma_ctrl: RTL
======================

JTPOPEYE_DMA_CTRL -- requirements
Module: jtpopeye_dma_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: system clock; all state updates on rising edge, gated by cen5.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have port cen5, input, 1 bit: 5 MHz clock enable; one-cycle pulse.
REQ-004 SHALL have port VB, input, 1 bit: vertical blank from the video timing generator.
REQ-005 SHALL have port dma_trig, input, 1 bit: CPU write strobe to the DMA trigger register; one-clk pulse, not cen-aligned.
REQ-006 SHALL have port cpu_rq, input, 1 bit: CPU requests the shared main RAM.
REQ-007 SHALL have port ram_dout, input, 8 bits: main RAM read data, valid one cen5 tick after the address is driven.
REQ-008 SHALL have port cpu_wait_n, output, 1 bit: CPU wait; 0 stalls the CPU.
REQ-009 SHALL have port bus_dma, output, 1 bit: 1 routes the main RAM address mux to dma_addr.
REQ-010 SHALL have port dma_addr, output, 8 bits: main RAM sprite table offset.
REQ-011 SHALL have port obj_addr, output, 8 bits: object RAM write address.
REQ-012 SHALL have port obj_din, output, 8 bits: object RAM write data.
REQ-013 SHALL have port obj_we, output, 1 bit: object RAM write enable.
REQ-014 SHALL have port dma_busy, output, 1 bit: high from arming until transfer completion.

Function
REQ-015 SHALL implement states IDLE, ARMED, RD, WR, DONE; every transition is taken only on a clk edge with cen5=1.
REQ-016 SHALL capture dma_trig into a pending flag on any clk edge, independent of cen5.
REQ-017 SHALL move IDLE->ARMED when pending=1, clearing pending on the same tick.
REQ-018 SHALL move ARMED->RD on a rising VB edge, detected against a VB copy registered on cen5; VB already high at arming SHALL NOT start the transfer.
REQ-019 SHALL clear the 8-bit byte counter cnt to 0 on ARMED->RD.
REQ-020 In RD, SHALL drive dma_addr=cnt and bus_dma=1, then advance to WR on the next tick.
REQ-021 In WR, SHALL register obj_din=ram_dout and obj_addr=cnt, and pulse obj_we for exactly one cen5 tick.
REQ-022 From WR, SHALL go to RD with cnt+1 when cnt<159, and to DONE when cnt=159: 160 bytes, 320 cen5 ticks total.
REQ-023 SHALL move DONE->IDLE after one tick; dma_busy falls on that transition.
REQ-024 SHALL hold pending when dma_trig arrives during ARMED/RD/WR/DONE, and re-arm from IDLE on the following tick.
REQ-025 SHALL abort on VB falling while in RD or WR: go to ARMED, leave object RAM partially written, restart at cnt=0 on the next VB rising edge.
REQ-026 SHALL hold bus_dma=1 only in RD and WR.
REQ-027 SHALL drive cpu_wait_n = ~(cpu_rq & bus_dma); CPU requests outside RD/WR are never stalled.
REQ-028 SHALL keep dma_busy=1 in ARMED, RD, WR and DONE.
REQ-029 SHALL hold all outputs when cen5=0, except cpu_wait_n, which tracks cpu_rq combinationally.

Reset
REQ-030 rst_n=0 SHALL force state IDLE and set pending=0, cnt=0, dma_addr=0, obj_addr=0, obj_din=0, obj_we=0, bus_dma=0, dma_busy=0; cpu_wait_n=1 follows from bus_dma=0.
REQ-031 Reset asserted mid-transfer SHALL abort immediately, with no further obj_we pulses.

Verification
REQ-032 Trigger in active video, then VB rises -> 160 obj_we pulses, obj_addr 0..159, obj_din equals ram_dout pattern, dma_busy falls after cnt=159.
REQ-033 Trigger while VB=1 -> no transfer until the next VB rising edge.
REQ-034 cpu_rq=1 during RD/WR -> cpu_wait_n=0; cpu_rq=1 in IDLE -> cpu_wait_n=1.
REQ-035 VB falls at cnt=80 -> abort to ARMED; next VB rise restarts at obj_addr=0.
REQ-036 Second dma_trig during transfer -> after DONE, IDLE->ARMED; second transfer on the next VB rising edge.
REQ-037 rst_n pulsed low at cnt=40 -> all outputs reset values; obj_we stays 0; dma_busy=0.

Source files
------------

// File: rtl/jtpopeye_dma_ctrl.sv
// Sprite-table DMA for Popeye: on a CPU trigger, waits for the next vertical
// blank and copies 160 bytes from main RAM into object RAM, stalling the CPU.
module jtpopeye_dma_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen5,
    input  logic       VB,
    input  logic       dma_trig,
    input  logic       cpu_rq,
    input  logic [7:0] ram_dout,
    output logic       cpu_wait_n,
    output logic       bus_dma,
    output logic [7:0] dma_addr,
    output logic [7:0] obj_addr,
    output logic [7:0] obj_din,
    output logic       obj_we,
    output logic       dma_busy
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_RD    = 3'd2,
        ST_WR    = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [7:0] LAST_BYTE = 8'd159;

    state_t     state_q, state_d;
    logic       pending_q, pending_d;
    logic       vb_q, vb_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] dma_addr_q, dma_addr_d;
    logic [7:0] obj_addr_q, obj_addr_d;
    logic [7:0] obj_din_q, obj_din_d;
    logic       obj_we_q, obj_we_d;
    logic       bus_dma_q, bus_dma_d;
    logic       dma_busy_q, dma_busy_d;
    logic       vb_rise_s, vb_fall_s;

    assign vb_rise_s = VB & ~vb_q;
    assign vb_fall_s = ~VB & vb_q;

    // Next-state and output computation; everything except the trigger latch moves only on cen5
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q | dma_trig;
        vb_d       = vb_q;
        cnt_d      = cnt_q;
        dma_addr_d = dma_addr_q;
        obj_addr_d = obj_addr_q;
        obj_din_d  = obj_din_q;
        obj_we_d   = obj_we_q;
        bus_dma_d  = bus_dma_q;
        dma_busy_d = dma_busy_q;
        if (cen5) begin
            vb_d     = VB;
            obj_we_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pending_q) begin
                        state_d    = ST_ARMED;
                        dma_busy_d = 1'b1;
                        // a trigger landing on this very edge must survive the clear
                        pending_d  = dma_trig;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ARMED: begin
                    if (vb_rise_s) begin
                        state_d    = ST_RD;
                        cnt_d      = 8'd0;
                        dma_addr_d = 8'd0;
                        bus_dma_d  = 1'b1;
                    end else begin
                        state_d = ST_ARMED;
                    end
                end
                ST_RD: begin
                    if (vb_fall_s) begin
                        state_d   = ST_ARMED;
                        bus_dma_d = 1'b0;
                    end else begin
                        state_d = ST_WR;
                    end
                end
                ST_WR: begin
                    if (vb_fall_s) begin
                        state_d   = ST_ARMED;
                        bus_dma_d = 1'b0;
                    end else begin
                        obj_din_d  = ram_dout;
                        obj_addr_d = cnt_q;
                        obj_we_d   = 1'b1;
                        if (cnt_q == LAST_BYTE) begin
                            state_d   = ST_DONE;
                            bus_dma_d = 1'b0;
                        end else begin
                            state_d    = ST_RD;
                            cnt_d      = cnt_q + 8'd1;
                            dma_addr_d = cnt_q + 8'd1;
                        end
                    end
                end
                ST_DONE: begin
                    state_d    = ST_IDLE;
                    dma_busy_d = 1'b0;
                end
                default: begin
                    state_d    = ST_IDLE;
                    bus_dma_d  = 1'b0;
                    dma_busy_d = 1'b0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pending_q  <= 1'b0;
            vb_q       <= 1'b0;
            cnt_q      <= 8'd0;
            dma_addr_q <= 8'd0;
            obj_addr_q <= 8'd0;
            obj_din_q  <= 8'd0;
            obj_we_q   <= 1'b0;
            bus_dma_q  <= 1'b0;
            dma_busy_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            vb_q       <= vb_d;
            cnt_q      <= cnt_d;
            dma_addr_q <= dma_addr_d;
            obj_addr_q <= obj_addr_d;
            obj_din_q  <= obj_din_d;
            obj_we_q   <= obj_we_d;
            bus_dma_q  <= bus_dma_d;
            dma_busy_q <= dma_busy_d;
        end
    end

    assign bus_dma    = bus_dma_q;
    assign dma_addr   = dma_addr_q;
    assign obj_addr   = obj_addr_q;
    assign obj_din    = obj_din_q;
    assign obj_we     = obj_we_q;
    assign dma_busy   = dma_busy_q;
    // the stall must react to cpu_rq within the same clock, so it stays combinational
    assign cpu_wait_n = ~(cpu_rq & bus_dma_q);

endmodule
